// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU command sequencer.
//               Holds the sequencer FSM state encoding, the opcode values
//               used when exercising the attached ALU, and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Default operand/result width; must match the attached ALU
    localparam int DEFAULT_DATA_W = 4;
    // Default opcode width
    localparam int DEFAULT_OP_W   = 3;

    // ALU opcodes (the sequencer itself never decodes these)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous command FIFO. Full/empty are derived from an
//               extra wrap bit on each pointer. No push/pop bypass: a push
//               into a full FIFO is dropped even if a pop happens in the
//               same cycle. The head entry is presented combinationally.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               push, wdata   - write request and entry to store
//               pop, rdata    - read request and current head entry
//               full, empty   - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with opposite wrap bits means the writer lapped the reader
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign rdata = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Command front-end for a combinational 4-bit ALU. Commands
//               are buffered in a FIFO, issued one at a time onto registered
//               ALU operand/opcode lines, and the ALU result is captured one
//               cycle later and offered on a valid/ready response port.
// Ports       : clk, rst_n               - clock, async active-low reset
//               cmd_valid/ready/a/b/op   - command input handshake
//               alu_a/alu_b/alu_op       - registered ALU drive
//               alu_result               - ALU result return
//               rsp_valid/ready/result/op- response output handshake
//               rsp_zero                 - result-is-zero flag (optional)
//               busy                     - FSM active or FIFO not empty
// Options     : ALU_SEQ_ZERO_FLAG_EN - adds the rsp_zero output
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int OP_W   = DEFAULT_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [OP_W-1:0]   rsp_op,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic              rsp_zero,
`endif
    output logic              busy
);

    localparam int c_ENTRY_W = 2 * DATA_W + OP_W;

    seq_state_t           r_state;
    logic [c_ENTRY_W-1:0] w_wdata;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    // The head is consumed only when the FSM is ready to issue it
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_wdata   = {cmd_a, cmd_b, cmd_op};
    assign busy      = (r_state != ST_IDLE) || !w_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            rsp_zero   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        alu_a   <= w_head[c_ENTRY_W-1 -: DATA_W];
                        alu_b   <= w_head[OP_W +: DATA_W];
                        alu_op  <= w_head[OP_W-1:0];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU has had a full cycle to settle on the issued operands
                    rsp_result <= alu_result;
                    rsp_op     <= alu_op;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    rsp_zero   <= (alu_result == '0);
`endif
                    rsp_valid  <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with a behavioural
//               4-bit ALU attached. Directed commands push hand-computed
//               expected responses into a scoreboard queue; a monitor pops
//               and compares on every accepted response.
// Options     : ALU_SEQ_ZERO_FLAG_EN - also checks rsp_zero
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] res;
        logic [2:0] op;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_zero;
    logic       busy;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream combinational ALU
    always_comb begin
        alu_result = alu_a ^ alu_b;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

`ifndef ALU_SEQ_ZERO_FLAG_EN
    assign rsp_zero = 1'b0;
`endif

    alu_cmd_sequencer #(
        .DEPTH  (DEPTH),
        .DATA_W (4),
        .OP_W   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .busy       (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one command until accepted; record its expected response
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] res, input logic zero);
        bit acc = 1'b0;
        int waited = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!acc && waited < 40) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        cmd_valid = 1'b0;
        if (acc) sb_q.push_back('{res: res, op: op, zero: zero});
        else     check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((sb_q.size() != 0 || busy || rsp_valid) && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain_pending", sb_q.size(), 0);
        check("drain_busy", int'(busy), 0);
    endtask

    // Monitor: each accepted response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got result %0d op %0d, expected none",
                         rsp_result, rsp_op);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_result", int'(rsp_result), int'(mon_e.res));
                check("rsp_op", int'(rsp_op), int'(mon_e.op));
`ifdef ALU_SEQ_ZERO_FLAG_EN
                check("rsp_zero", int'(rsp_zero), int'(mon_e.zero));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int acc6;
        // ---------------- reset, with a push attempt held during reset
        rst_n = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd4; cmd_op = 3'd0;
        #1;
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_alu_a", int'(alu_a), 0);
        check("post_reset_alu_b", int'(alu_b), 0);
        check("post_reset_alu_op", int'(alu_op), 0);
        check("post_reset_rsp_result", int'(rsp_result), 0);
        check("post_reset_rsp_op", int'(rsp_op), 0);
        check("post_reset_rsp_valid", int'(rsp_valid), 0);

        // ---------------- latency: 2 + 5 = 7
        send(4'b0010, 4'b0101, OP_ADD, 4'b0111, 1'b0);
        check("lat_n_rsp_valid", int'(rsp_valid), 0);
        check("lat_n_busy", int'(busy), 1);
        @(posedge clk); #1;
        check("lat_n1_alu_a", int'(alu_a), 2);
        check("lat_n1_alu_b", int'(alu_b), 5);
        check("lat_n1_alu_op", int'(alu_op), 0);
        check("lat_n1_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk); #1;
        check("lat_n2_rsp_valid", int'(rsp_valid), 1);
        wait_idle();
        check("alu_hold_a", int'(alu_a), 2);

        // ---------------- arithmetic and wrap vectors
        send(4'b0101, 4'b0010, OP_SUB, 4'b0011, 1'b0);
        send(4'b1111, 4'b0001, OP_ADD, 4'b0000, 1'b1);
        send(4'b0010, 4'b0101, OP_SUB, 4'b1101, 1'b0);
        send(4'b1001, 4'b1001, OP_ADD, 4'b0010, 1'b0);
        send(4'b0110, 4'b0011, 3'b101, 4'b0101, 1'b0);
        wait_idle();

        // ---------------- back-pressure: 5 accepted, 6th refused
        rsp_ready = 1'b0;
        send(4'd1, 4'd1, OP_ADD, 4'd2,  1'b0);
        send(4'd3, 4'd4, OP_ADD, 4'd7,  1'b0);
        send(4'd8, 4'd3, OP_SUB, 4'd5,  1'b0);
        send(4'd0, 4'd1, OP_SUB, 4'd15, 1'b0);
        send(4'd7, 4'd8, OP_ADD, 4'd15, 1'b0);
        check("bp_cmd_ready", int'(cmd_ready), 0);
        acc6 = 0;
        cmd_a = 4'd4; cmd_b = 4'd4; cmd_op = OP_ADD; cmd_valid = 1'b1;
        // Response hold: first response must stay put while not accepted
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cmd_ready) acc6++;
            check("hold_rsp_valid", int'(rsp_valid), 1);
            check("hold_rsp_result", int'(rsp_result), 2);
            check("hold_rsp_op", int'(rsp_op), 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("bp_sixth_refused", acc6, 0);
        rsp_ready = 1'b1;
        wait_idle();
        check("bp_ready_again", int'(cmd_ready), 1);

        // ---------------- reset while in RESP with 3 entries queued
        rsp_ready = 1'b0;
        send(4'd1, 4'd2, OP_ADD, 4'd3, 1'b0);
        send(4'd3, 4'd3, OP_ADD, 4'd6, 1'b0);
        send(4'd4, 4'd1, OP_SUB, 4'd3, 1'b0);
        send(4'd5, 4'd5, OP_ADD, 4'd10, 1'b0);
        check("rst_pre_rsp_valid", int'(rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_rsp_valid", int'(rsp_valid), 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        check("rst_rel_busy", int'(busy), 0);
        check("rst_rel_cmd_ready", int'(cmd_ready), 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        check("rst_no_stale", seen, 0);
        @(posedge clk); #1;
        send(4'd6, 4'd7, OP_ADD, 4'd13, 1'b0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
